// File: rtl/uart_text_rx_if.sv
// uart_text_rx_if: received-character bundle from uart_text_rx to its consumer
interface uart_text_rx_if;
  logic [7:0] text;
  logic       text_in;
  logic       frame_err;
  logic       parity_err;
  logic       busy;
  modport master(output text, text_in, frame_err, parity_err, busy);
  modport slave(input text, text_in, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_text_rx.sv
// uart_text_rx: 8N1 UART receiver feeding the text/text_in character stream
// Define UART_RX_PARITY_EN to add an even-parity bit after D7.
module uart_text_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input logic CLK,
  input logic RST,
  input logic rx,
  uart_text_rx_if.master o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] AFTER_DATA = PARITY;
`else
  localparam logic [2:0] AFTER_DATA = STOP;
`endif
  logic [SYNC_STAGES-1:0] sync;
  logic [2:0] state;
  logic [CW-1:0] clk_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift, text;
  logic text_in, frame_err, parity_err, armed, par_bad;
  logic rx_s, bit_end, mid_start, good;
  assign rx_s      = sync[SYNC_STAGES-1];
  assign bit_end   = clk_cnt == CW'(CLKS_PER_BIT - 1);
  assign mid_start = clk_cnt == CW'(CLKS_PER_BIT / 2 - 1);
  assign good      = rx_s && !par_bad;
  assign o.text       = text;
  assign o.text_in    = text_in;
  assign o.frame_err  = frame_err;
  assign o.parity_err = parity_err;
  assign o.busy       = state != IDLE;
`ifndef UART_RX_PARITY_EN
  assign par_bad = 1'b0;
`endif
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync       <= '1;
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      text       <= '0;
      text_in    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      armed      <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
`endif
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], rx};
      text_in    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      clk_cnt    <= bit_end ? '0 : clk_cnt + 1'b1;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          // after a broken stop bit the line must go high before a new start counts
          if (rx_s) armed <= 1'b1;
          else if (armed) state <= START;
        end
        START: if (mid_start) begin
          clk_cnt <= '0;
          bit_idx <= '0;
          state   <= rx_s ? IDLE : DATA;
        end
        DATA: if (bit_end) begin
          shift[bit_idx] <= rx_s;
          bit_idx        <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) state <= AFTER_DATA;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (bit_end) begin
          par_bad <= (^shift) != rx_s;
          state   <= STOP;
        end
`endif
        STOP: if (bit_end) begin
          state      <= IDLE;
          armed      <= rx_s;
          frame_err  <= !rx_s;
          parity_err <= par_bad;
          text_in    <= good;
          if (good) text <= shift;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_text_rx.sv
// tb_uart_text_rx: directed and randomized frame checks against a byte-level model
module tb_uart_text_rx;
  localparam int CPB = 16;
  localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic rx = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  logic [7:0] got_q[$];
  int t_q[$];
  uart_text_rx_if bus ();
  uart_text_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .CLK(CLK), .RST(RST), .rx(rx), .o(bus.master)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (bus.text_in === 1'b1) begin
      got_q.push_back(bus.text);
      t_q.push_back(cyc);
    end
    if (bus.frame_err === 1'b1) fe_cnt++;
    if (bus.parity_err === 1'b1) pe_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic put(input logic v);
    rx = v;
    repeat (CPB) @(negedge CLK);
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input logic pflip);
    put(1'b0);
    for (int i = 0; i < 8; i++) put(b[i]);
    if (PAR) put((^b) ^ pflip);
    put(stop);
    rx = 1'b1;
  endtask
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge CLK);
  endtask
  task automatic clear();
    got_q.delete();
    t_q.delete();
    fe_cnt = 0;
    pe_cnt = 0;
  endtask
  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] b, last;
    logic stop, flip;
    int t0, exp_fe, exp_pe;
    logic [7:0] bb[3];
    repeat (3) @(negedge CLK);
    check("rst_text", 32'(bus.text), 32'h00);
    check("rst_text_in", 32'(bus.text_in), 32'h0);
    check("rst_frame_err", 32'(bus.frame_err), 32'h0);
    check("rst_parity_err", 32'(bus.parity_err), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    RST = 1'b1;
    idle(4);
    clear();
    rx = 1'b0;
    repeat (50) @(negedge CLK);
    check("mid_busy_before", 32'(bus.busy), 32'h1);
    #2 RST = 1'b0;
    #1;
    check("mid_busy_after", 32'(bus.busy), 32'h0);
    check("mid_text_in", 32'(bus.text_in), 32'h0);
    rx = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    idle(200);
    check("mid_no_strobe", 32'(got_q.size()), 32'd0);
    check("mid_text", 32'(bus.text), 32'h00);
    clear();
    t0 = cyc;
    send(8'h4B, 1'b1, 1'b0);
    idle(20);
    check("single_count", 32'(got_q.size()), 32'd1);
    check("single_text", got_q.size() > 0 ? 32'(got_q[0]) : 32'hdead, 32'h4B);
    check("single_latency_ok", (t_q.size() > 0 && t_q[0] - t0 >= 145 + 16 * int'(PAR) && t_q[0] - t0 <= 165 + 16 * int'(PAR)) ? 32'd1 : 32'd0, 32'd1);
    clear();
    bb = '{8'h4B, 8'h45, 8'h59};
    for (int i = 0; i < 3; i++) send(bb[i], 1'b1, 1'b0);
    idle(20);
    check("b2b_count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("b2b_text%0d", i), i < got_q.size() ? 32'(got_q[i]) : 32'hdead, 32'(bb[i]));
    for (int i = 1; i < 3; i++)
      check($sformatf("b2b_gap%0d", i), i < t_q.size() ? 32'(t_q[i] - t_q[i-1]) : 32'hdead, 32'(10 * CPB + 16 * int'(PAR)));
    clear();
    send(8'hAA, 1'b0, 1'b0);
    idle(2 * CPB);
    check("badstop_frame_err", 32'(fe_cnt), 32'd1);
    check("badstop_no_strobe", 32'(got_q.size()), 32'd0);
    check("badstop_text_kept", 32'(bus.text), 32'h59);
    send(8'h11, 1'b1, 1'b0);
    idle(20);
    check("recover_count", 32'(got_q.size()), 32'd1);
    check("recover_text", 32'(bus.text), 32'h11);
    clear();
    rx = 1'b0;
    repeat (4) @(negedge CLK);
    check("glitch_busy_seen", 32'(bus.busy), 32'h1);
    rx = 1'b1;
    repeat (8) @(negedge CLK);
    check("glitch_busy_clear", 32'(bus.busy), 32'h0);
    idle(200);
    check("glitch_no_strobe", 32'(got_q.size()), 32'd0);
    check("glitch_no_ferr", 32'(fe_cnt), 32'd0);
`ifdef UART_RX_PARITY_EN
    clear();
    send(8'h4B, 1'b1, 1'b0);
    idle(20);
    check("par_good_count", 32'(got_q.size()), 32'd1);
    check("par_good_text", 32'(bus.text), 32'h4B);
    check("par_good_perr", 32'(pe_cnt), 32'd0);
    clear();
    send(8'h4C, 1'b1, 1'b1);
    idle(20);
    check("par_bad_perr", 32'(pe_cnt), 32'd1);
    check("par_bad_no_strobe", 32'(got_q.size()), 32'd0);
    check("par_bad_text_kept", 32'(bus.text), 32'h4B);
`endif
    clear();
    last = bus.text;
    exp_fe = 0;
    exp_pe = 0;
    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom);
      stop = $urandom_range(0, 4) != 0;
      flip = PAR && ($urandom_range(0, 4) == 0);
      send(b, stop, flip);
      exp_fe += int'(!stop);
      exp_pe += int'(flip);
      if (stop && !flip) begin
        exp_q.push_back(b);
        last = b;
      end
      idle(stop ? $urandom_range(0, 3) : 2 * CPB);
    end
    idle(40);
    check("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("rand_text%0d", i), i < got_q.size() ? 32'(got_q[i]) : 32'hdead, 32'(exp_q[i]));
    check("rand_frame_err", 32'(fe_cnt), 32'(exp_fe));
    check("rand_parity_err", 32'(pe_cnt), 32'(exp_pe));
    check("rand_text_hold", 32'(bus.text), 32'(last));
    check("rand_idle_busy", 32'(bus.busy), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_text_rx.md
Name: uart_text_rx

Overview:
- Serial byte receiver that produces the `text`/`text_in` character stream consumed by the VGA interrupt generator.
- Deserialises 8N1 UART frames from a single RX pin and emits each good byte with a one-cycle valid strobe.
- Flags framing errors on a separate pulse.
- Sits between the board RX pad and `VGA_INT_GEN`.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Legal range 4 or more.
- SYNC_STAGES, 2, flip-flops in the RX metastability synchroniser. Legal range 2 or more.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- rx  input  1  raw serial line; idles high.
- text  output  8  last correctly received byte.
- text_in  output  1  one-cycle strobe; `text` is valid and new in that cycle.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- parity_err  output  1  one-cycle pulse on parity mismatch; held 0 when the feature is absent.
- busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (RST=0, asynchronous):
  - Outputs: text=8'h00, text_in=0, frame_err=0, parity_err=0, busy=0.
  - State returns to IDLE; synchroniser flops are set to 1.
  - Reset mid-frame discards the partial byte; no strobe is produced.
- The `rx` input passes through SYNC_STAGES flops; rx_s is the synchronised value.
- Bit counter:
  - clk_cnt is $clog2(CLKS_PER_BIT) bits wide and counts 0..CLKS_PER_BIT-1, then wraps to 0.
  - bit_idx is 3 bits wide.
- States and transitions:
  - IDLE: when rx_s=0, go to START with clk_cnt=0.
  - START: when clk_cnt reaches CLKS_PER_BIT/2-1 (mid start bit):
    - rx_s=0: go to DATA with clk_cnt=0 and bit_idx=0.
    - rx_s=1: treat as a glitch and return to IDLE with no output.
  - DATA: each time clk_cnt reaches CLKS_PER_BIT-1, sample rx_s into shift[bit_idx], LSB first.
    - After bit_idx=7 is sampled, go to STOP (or PARITY when the feature is present).
  - STOP: when clk_cnt reaches CLKS_PER_BIT-1 (mid stop bit), sample rx_s, then go to IDLE.
    - rx_s=1 and no parity error: on the next edge, text is loaded from shift and text_in=1 for exactly one cycle.
    - rx_s=0: frame_err=1 for one cycle; text and text_in are unchanged.
- Latency: text_in rises one clock after the mid-stop sample point.
- Back-to-back frames: returning to IDLE at mid-stop lets a start edge immediately after the stop bit be caught. There are no dead cycles beyond the synchroniser delay.
- Line held low (break): produces frame_err once, then IDLE waits for rx_s=1 before accepting a new start.
- text holds its value between strobes. The downstream block must sample text only when text_in=1.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - One even-parity bit follows D7, sampled in state PARITY at mid-bit, then go to STOP.
  - Mismatch (^shift != parity bit) pulses parity_err for one cycle alongside the stop-bit decision.
  - On mismatch, text_in is suppressed and text is unchanged.
  - A frame with both parity and stop errors pulses both parity_err and frame_err.
- Undefined:
  - No PARITY state; frames are 8N1.
  - parity_err is tied to 0.

Test Plan (CLKS_PER_BIT=16 in all scenarios):
- Reset: hold RST=0 for 3 cycles with rx=1 -> text=00, text_in=0, frame_err=0, busy=0. Assert RST=0 mid-frame -> busy=0 immediately and no text_in follows.
- Single frame 0x4B sent LSB first (start, 1,1,0,1,0,0,1,0, stop) -> exactly one text_in pulse, text=8'h4B, text_in about 150 cycles after the start edge (9.5 bits plus synchroniser delay).
- Back-to-back 0x4B, 0x45, 0x59 with no idle gap -> three text_in pulses 160 cycles apart; text takes 4B, 45, 59 in order.
- Stop bit driven 0 with data 0xAA -> frame_err pulse, no text_in, text keeps its previous value; the next good frame 0x11 is received correctly.
- Start glitch: rx low for 4 cycles, then high -> no strobe, busy returns to 0 by cycle 8 + SYNC_STAGES.
- With UART_RX_PARITY_EN: 0x4B with parity bit 0 -> text_in, text=4B. 0x4B with parity bit 1 -> parity_err pulse, no text_in.
